// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback arbiter and its buffer.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding secondary (mul/div) results that lost the
// regfile write port. Exposes the destination of every slot plus a per-slot
// valid mask so the hazard compare can see all pending destinations at once.
module rf_wr_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          i_push,
  input  logic [REG_ADDR_W-1:0]         i_push_rd,
  input  logic [XLEN-1:0]               i_push_data,
  input  logic                          i_pop,
  output logic [REG_ADDR_W-1:0]         o_head_rd,
  output logic [XLEN-1:0]               o_head_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [DEPTH*REG_ADDR_W-1:0]   o_entry_rd,
  output logic [DEPTH-1:0]              o_entry_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rf_wr_req_t         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Distance of slot i from the read pointer; slots closer than the count hold live data.
  function automatic logic [CNT_W-1:0] slot_ofs(input int idx, input logic [PTR_W-1:0] rp);
    logic [PTR_W-1:0] d;
    d = PTR_W'(idx) - rp;
    return {1'b0, d};
  endfunction

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;

  assign o_head_rd   = r_mem[r_rd_ptr].rd;
  assign o_head_data = r_mem[r_rd_ptr].data;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Entry storage carries no reset; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{rd: i_push_rd, data: i_push_data};
  end

  // Flat view of slot destinations and which slots are currently occupied.
  always_comb begin
    o_entry_rd  = '0;
    o_entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_rd[i*REG_ADDR_W +: REG_ADDR_W] = r_mem[i].rd;
      o_entry_vld[i] = (slot_ofs(i, r_rd_ptr) < r_count);
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter. The in-order MEM/WB writeback has
// priority; mul/div results bypass straight to the port when nothing is
// buffered, otherwise queue in rf_wr_fifo. A full or starved buffer forces a
// drain that freezes the pipeline. Pending destinations are compared against
// the ID-stage registers so dependent instructions can be held back.
module rf_wr_arb
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        MemWb_RegWrite,
  input  logic [4:0]  MemWb_RegRd,
  input  logic [31:0] Wb_RegWData,
  input  logic        Md_Valid,
  input  logic [4:0]  Md_RegRd,
  input  logic [31:0] Md_Data,
  output logic        Md_Ready,
  input  logic [4:0]  IfId_Rs1,
  input  logic [4:0]  IfId_Rs2,
  input  logic [4:0]  IfId_Rd,
  output logic        Arb_RawHit,
  output logic        Arb_Stall,
  output logic        Rf_Write,
  output logic [4:0]  Rf_Addr,
  output logic [31:0] Rf_WData
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  arb_state_t                   r_state;
  arb_state_t                   w_state_nxt;
  logic [ST_W-1:0]              r_starve;
  logic [ST_W-1:0]              w_starve_nxt;
  logic                         r_stall;

  logic                         w_preq;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_bypass;
  logic                         w_full;
  logic                         w_empty;
  logic [CNT_W-1:0]             w_count;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic [REG_ADDR_W-1:0]        w_head_rd;
  logic [XLEN-1:0]              w_head_data;
  logic [DEPTH*REG_ADDR_W-1:0]  w_entry_rd;
  logic [DEPTH-1:0]             w_entry_vld;

  // A destination hits when it is a real register named by the ID stage.
  function automatic logic id_match(input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs1,
                                    input logic [REG_ADDR_W-1:0] rs2,
                                    input logic [REG_ADDR_W-1:0] idrd);
    return (rd != '0) && ((rd == rs1) || (rd == rs2) || (rd == idrd));
  endfunction

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstb        (rstb),
    .i_push      (w_push),
    .i_push_rd   (Md_RegRd),
    .i_push_data (Md_Data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_entry_rd  (w_entry_rd),
    .o_entry_vld (w_entry_vld)
  );

  // x0 writes are not real requests from either source.
  assign w_preq    = MemWb_RegWrite && (MemWb_RegRd != '0);
  // A full buffer refuses even when it pops this cycle, keeping Md_Ready off the pop path.
  assign Md_Ready  = !w_full && rstb;
  assign w_push    = Md_Valid && Md_Ready && (Md_RegRd != '0) && !w_bypass;
  assign w_cnt_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign Arb_Stall = r_stall;

  // Write-port priority: drain head, primary, buffered head, direct bypass.
  always_comb begin
    Rf_Write = 1'b0;
    Rf_Addr  = '0;
    Rf_WData = '0;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    if (rstb) begin
      if (r_state == DRAIN) begin
        if (!w_empty) begin
          Rf_Write = 1'b1;
          Rf_Addr  = w_head_rd;
          Rf_WData = w_head_data;
          w_pop    = 1'b1;
        end
      end else if (w_preq) begin
        Rf_Write = 1'b1;
        Rf_Addr  = MemWb_RegRd;
        Rf_WData = Wb_RegWData;
      end else if (!w_empty) begin
        Rf_Write = 1'b1;
        Rf_Addr  = w_head_rd;
        Rf_WData = w_head_data;
        w_pop    = 1'b1;
      end else if (Md_Valid && (Md_RegRd != '0)) begin
        Rf_Write = 1'b1;
        Rf_Addr  = Md_RegRd;
        Rf_WData = Md_Data;
        w_bypass = 1'b1;
      end
    end
  end

  // Starvation count: cycles the buffered head waits; cleared by a pop or an empty buffer.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve < ST_W'(STARVE_MAX)) begin
      w_starve_nxt = r_starve + ST_W'(1);
    end
  end

  // Enter drain when the buffer fills or the head starves; leave once the last entry pops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if ((w_cnt_nxt == CNT_W'(DEPTH)) || (w_starve_nxt == ST_W'(STARVE_MAX))) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_cnt_nxt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, starvation counter and the registered pipeline freeze.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_state_nxt == DRAIN);
    end
  end

  // Hazard: any occupied slot or an arriving result naming an ID-stage register.
  always_comb begin
    Arb_RawHit = Md_Valid && id_match(Md_RegRd, IfId_Rs1, IfId_Rs2, IfId_Rd);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_vld[i] &&
          id_match(w_entry_rd[i*REG_ADDR_W +: REG_ADDR_W], IfId_Rs1, IfId_Rs2, IfId_Rd)) begin
        Arb_RawHit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: inputs change 1ns after the rising edge,
// combinational and registered outputs are checked mid-cycle.
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        rstb;
  logic        MemWb_RegWrite;
  logic [4:0]  MemWb_RegRd;
  logic [31:0] Wb_RegWData;
  logic        Md_Valid;
  logic [4:0]  Md_RegRd;
  logic [31:0] Md_Data;
  logic        Md_Ready;
  logic [4:0]  IfId_Rs1;
  logic [4:0]  IfId_Rs2;
  logic [4:0]  IfId_Rd;
  logic        Arb_RawHit;
  logic        Arb_Stall;
  logic        Rf_Write;
  logic [4:0]  Rf_Addr;
  logic [31:0] Rf_WData;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rf_wr_arb #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .MemWb_RegWrite (MemWb_RegWrite),
    .MemWb_RegRd    (MemWb_RegRd),
    .Wb_RegWData    (Wb_RegWData),
    .Md_Valid       (Md_Valid),
    .Md_RegRd       (Md_RegRd),
    .Md_Data        (Md_Data),
    .Md_Ready       (Md_Ready),
    .IfId_Rs1       (IfId_Rs1),
    .IfId_Rs2       (IfId_Rs2),
    .IfId_Rd        (IfId_Rd),
    .Arb_RawHit     (Arb_RawHit),
    .Arb_Stall      (Arb_Stall),
    .Rf_Write       (Rf_Write),
    .Rf_Addr        (Rf_Addr),
    .Rf_WData       (Rf_WData)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    MemWb_RegWrite = 1'b0; MemWb_RegRd = '0; Wb_RegWData = '0;
    Md_Valid = 1'b0; Md_RegRd = '0; Md_Data = '0;
    IfId_Rs1 = '0; IfId_Rs2 = '0; IfId_Rd = '0;
  endtask

  task automatic prim(input logic [4:0] rd, input logic [31:0] d);
    MemWb_RegWrite = 1'b1; MemWb_RegRd = rd; Wb_RegWData = d;
  endtask

  task automatic md(input logic [4:0] rd, input logic [31:0] d);
    Md_Valid = 1'b1; Md_RegRd = rd; Md_Data = d;
  endtask

  task automatic test_reset;
    idle_in();
    rstb = 1'b0;
    prim(5'd3, 32'h55);
    md(5'd4, 32'h44);
    #4;
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL rst_we: got %0b want 0", Rf_Write); end
    nvec++; if (Md_Ready !== 1'b0) begin nerr++; $display("FAIL rst_rdy: got %0b want 0", Md_Ready); end
    tick();
    #4;
    nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL rst_stall: got %0b want 0", Arb_Stall); end
    tick();
    idle_in();
    rstb = 1'b1;
    #4;
    nvec++; if (Md_Ready !== 1'b1) begin nerr++; $display("FAIL rst_rdy_rel: got %0b want 1", Md_Ready); end
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL rst_we_rel: got %0b want 0", Rf_Write); end
    tick();
  endtask

  task automatic test_bypass;
    idle_in();
    md(5'd5, 32'h1234);
    #4;
    nvec++; if (Rf_Write !== 1'b1) begin nerr++; $display("FAIL byp_we: got %0b want 1", Rf_Write); end
    nvec++; if (Rf_Addr !== 5'd5) begin nerr++; $display("FAIL byp_addr: got %0d want 5", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'h1234) begin nerr++; $display("FAIL byp_data: got %h want 1234", Rf_WData); end
    tick();
    idle_in();
    IfId_Rs1 = 5'd5;
    #4;
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL byp_nobuf_we: got %0b want 0", Rf_Write); end
    nvec++; if (Arb_RawHit !== 1'b0) begin nerr++; $display("FAIL byp_nobuf_hit: got %0b want 0", Arb_RawHit); end
    tick();
  endtask

  task automatic test_conflict;
    idle_in();
    prim(5'd3, 32'hAAAA);
    md(5'd7, 32'hBBBB);
    #4;
    nvec++; if (Rf_Addr !== 5'd3) begin nerr++; $display("FAIL cf_addr0: got %0d want 3", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'hAAAA) begin nerr++; $display("FAIL cf_data0: got %h want aaaa", Rf_WData); end
    nvec++; if (Md_Ready !== 1'b1) begin nerr++; $display("FAIL cf_rdy: got %0b want 1", Md_Ready); end
    tick();
    idle_in();
    IfId_Rd = 5'd7;
    #4;
    nvec++; if (Arb_RawHit !== 1'b1) begin nerr++; $display("FAIL cf_waw: got %0b want 1", Arb_RawHit); end
    nvec++; if (Rf_Write !== 1'b1) begin nerr++; $display("FAIL cf_we1: got %0b want 1", Rf_Write); end
    nvec++; if (Rf_Addr !== 5'd7) begin nerr++; $display("FAIL cf_addr1: got %0d want 7", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'hBBBB) begin nerr++; $display("FAIL cf_data1: got %h want bbbb", Rf_WData); end
    tick();
    #4;
    nvec++; if (Arb_RawHit !== 1'b0) begin nerr++; $display("FAIL cf_waw_clr: got %0b want 0", Arb_RawHit); end
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL cf_we2: got %0b want 0", Rf_Write); end
    tick();
  endtask

  task automatic test_full_drain;
    idle_in();
    prim(5'd1, 32'h11);
    md(5'd10, 32'hA0);
    #4;
    nvec++; if (Rf_Addr !== 5'd1) begin nerr++; $display("FAIL fd_addr_a: got %0d want 1", Rf_Addr); end
    tick();
    prim(5'd2, 32'h22);
    md(5'd11, 32'hB0);
    #4;
    nvec++; if (Md_Ready !== 1'b1) begin nerr++; $display("FAIL fd_rdy_b: got %0b want 1", Md_Ready); end
    nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL fd_stall_b: got %0b want 0", Arb_Stall); end
    tick();
    Md_Valid = 1'b0;
    prim(5'd13, 32'hDD);
    #4;
    nvec++; if (Arb_Stall !== 1'b1) begin nerr++; $display("FAIL fd_stall_c: got %0b want 1", Arb_Stall); end
    nvec++; if (Md_Ready !== 1'b0) begin nerr++; $display("FAIL fd_rdy_full: got %0b want 0", Md_Ready); end
    nvec++; if (Rf_Addr !== 5'd10) begin nerr++; $display("FAIL fd_addr_c: got %0d want 10", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'hA0) begin nerr++; $display("FAIL fd_data_c: got %h want a0", Rf_WData); end
    tick();
    #4;
    nvec++; if (Arb_Stall !== 1'b1) begin nerr++; $display("FAIL fd_stall_d: got %0b want 1", Arb_Stall); end
    nvec++; if (Rf_Addr !== 5'd11) begin nerr++; $display("FAIL fd_addr_d: got %0d want 11", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'hB0) begin nerr++; $display("FAIL fd_data_d: got %h want b0", Rf_WData); end
    nvec++; if (Md_Ready !== 1'b1) begin nerr++; $display("FAIL fd_rdy_d: got %0b want 1", Md_Ready); end
    tick();
    idle_in();
    #4;
    nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL fd_stall_e: got %0b want 0", Arb_Stall); end
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL fd_we_e: got %0b want 0", Rf_Write); end
    tick();
  endtask

  task automatic test_starvation;
    idle_in();
    prim(5'd4, 32'h40);
    md(5'd6, 32'h60);
    tick();
    Md_Valid = 1'b0;
    prim(5'd8, 32'h80);
    for (int k = 1; k <= 4; k++) begin
      #4;
      nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL st_stall_c%0d: got %0b want 0", k, Arb_Stall); end
      nvec++; if (Rf_Addr !== 5'd8) begin nerr++; $display("FAIL st_addr_c%0d: got %0d want 8", k, Rf_Addr); end
      tick();
    end
    #4;
    nvec++; if (Arb_Stall !== 1'b1) begin nerr++; $display("FAIL st_stall_c5: got %0b want 1", Arb_Stall); end
    nvec++; if (Rf_Addr !== 5'd6) begin nerr++; $display("FAIL st_addr_c5: got %0d want 6", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'h60) begin nerr++; $display("FAIL st_data_c5: got %h want 60", Rf_WData); end
    tick();
    #4;
    nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL st_stall_c6: got %0b want 0", Arb_Stall); end
    nvec++; if (Rf_Addr !== 5'd8) begin nerr++; $display("FAIL st_addr_c6: got %0d want 8", Rf_Addr); end
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_hazard;
    idle_in();
    prim(5'd2, 32'h22);
    md(5'd9, 32'h99);
    tick();
    Md_Valid = 1'b0;
    IfId_Rs2 = 5'd9;
    #3;
    nvec++; if (Arb_RawHit !== 1'b1) begin nerr++; $display("FAIL hz_rs2: got %0b want 1", Arb_RawHit); end
    IfId_Rs2 = 5'd0;
    md(5'd0, 32'hEE);
    #2;
    nvec++; if (Arb_RawHit !== 1'b0) begin nerr++; $display("FAIL hz_x0: got %0b want 0", Arb_RawHit); end
    nvec++; if (Md_Ready !== 1'b1) begin nerr++; $display("FAIL hz_x0_rdy: got %0b want 1", Md_Ready); end
    tick();
    md(5'd12, 32'hCC);
    IfId_Rs1 = 5'd12;
    #3;
    nvec++; if (Arb_RawHit !== 1'b1) begin nerr++; $display("FAIL hz_incoming: got %0b want 1", Arb_RawHit); end
    Md_Valid = 1'b0;
    #2;
    nvec++; if (Arb_RawHit !== 1'b0) begin nerr++; $display("FAIL hz_incoming_off: got %0b want 0", Arb_RawHit); end
    tick();
    idle_in();
    IfId_Rs2 = 5'd9;
    #4;
    nvec++; if (Rf_Addr !== 5'd9) begin nerr++; $display("FAIL hz_addr: got %0d want 9", Rf_Addr); end
    nvec++; if (Rf_WData !== 32'h99) begin nerr++; $display("FAIL hz_data: got %h want 99", Rf_WData); end
    tick();
    #4;
    nvec++; if (Arb_RawHit !== 1'b0) begin nerr++; $display("FAIL hz_clear: got %0b want 0", Arb_RawHit); end
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL hz_nox0: got %0b want 0", Rf_Write); end
    tick();
  endtask

  task automatic test_reset_drain;
    idle_in();
    prim(5'd1, 32'h1);
    md(5'd20, 32'h20);
    tick();
    md(5'd21, 32'h21);
    tick();
    idle_in();
    #2;
    nvec++; if (Arb_Stall !== 1'b1) begin nerr++; $display("FAIL rd_stall_pre: got %0b want 1", Arb_Stall); end
    rstb = 1'b0;
    #2;
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL rd_we_rst: got %0b want 0", Rf_Write); end
    nvec++; if (Md_Ready !== 1'b0) begin nerr++; $display("FAIL rd_rdy_rst: got %0b want 0", Md_Ready); end
    tick();
    rstb = 1'b1;
    IfId_Rs1 = 5'd20;
    IfId_Rs2 = 5'd21;
    #3;
    nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL rd_stall: got %0b want 0", Arb_Stall); end
    nvec++; if (Md_Ready !== 1'b1) begin nerr++; $display("FAIL rd_rdy: got %0b want 1", Md_Ready); end
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL rd_we: got %0b want 0", Rf_Write); end
    nvec++; if (Arb_RawHit !== 1'b0) begin nerr++; $display("FAIL rd_hit: got %0b want 0", Arb_RawHit); end
    tick();
    #3;
    nvec++; if (Rf_Write !== 1'b0) begin nerr++; $display("FAIL rd_we_next: got %0b want 0", Rf_Write); end
    nvec++; if (Arb_Stall !== 1'b0) begin nerr++; $display("FAIL rd_stall_next: got %0b want 0", Arb_Stall); end
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_full_drain();
    test_starvation();
    test_hazard();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
